serial_sub_ctrl: RTL
====================

# serial_sub_ctrl

Bit-serial multi-bit subtractor controller. It latches two WIDTH-bit operands and a borrow-in, then drives a single one-bit full-subtractor cell LSB-first, one bit per clock. It reassembles the difference and final borrow and signals completion with a start/busy/done handshake. It lets one full-subtractor cell serve any operand width in area-constrained datapaths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on clk rising edge, accepted only in IDLE or DONE.
- a  in  WIDTH  minuend; sampled on the accepting edge only.
- b  in  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  in  1  initial borrow-in; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; high while in DONE.
- diff  out  WIDTH  registered result a - b - bin, modulo 2^WIDTH.
- bout  out  1  registered final borrow; 1 iff a < b + bin (unsigned).
- zero  out  1  result == 0; present only with SERIAL_SUB_FLAGS_EN.
- ovf  out  1  signed (two's-complement) overflow; present only with SERIAL_SUB_FLAGS_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start. The accepting edge loads the shift registers sa<=a and sb<=b, sets borrow<=bin, cnt<=0 and clears the internal result shift register.
- RUN: each edge computes one bit d and nb from x=sa[0], y=sb[0], c=borrow:
  - d = x^y^c
  - nb = (~x&y) | (c&(~x|y))
  - sa and sb shift right; d shifts into the result MSB; borrow<=nb; cnt<=cnt+1.
- RUN -> DONE on the edge that processes bit WIDTH-1 (cnt==WIDTH-1). The same edge loads diff with the fully assembled result, loads bout with nb and loads the flags if compiled in.
- DONE -> RUN if start is high (back-to-back; operands loaded as from IDLE); otherwise DONE -> IDLE.
- start in RUN is ignored, with no queueing or effect on the operation in progress.
- diff, bout and the flags hold their values until the next DONE entry. They never show partial results.
- Reset, asynchronous at any time including mid-RUN:
  - state=IDLE; busy=0, done=0, diff=0, bout=0, zero=0, ovf=0.
  - All internal registers are cleared.
  - An aborted operation produces no done.

## Timing
- Call the accepting edge E0. busy is high from E0 to E(WIDTH).
- done is high for exactly one cycle, from E(WIDTH) to E(WIDTH+1).
- Latency from accepting edge to done is WIDTH cycles.
- Throughput is one operation per WIDTH+1 cycles with idle gaps. Back-to-back via DONE gives the same WIDTH+1 period, because start raised during DONE is accepted at the DONE-exit edge.
- Counter width is $clog2(WIDTH); the counter never wraps within an operation.

## Configuration
- SERIAL_SUB_FLAGS_EN defined:
  - zero = (assembled result == 0).
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]), using the latched operand MSBs.
  - Both flags are registered at DONE entry alongside diff.
- Undefined: the zero and ovf ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package serial_sub_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the WIDTH legal-range constants, checked by an elaboration-time assertion.
- Sub-module fs_cell is a purely combinational one-bit full subtractor (inputs x, y, c; outputs d, nb; equations above), instantiated once.
- The controller holds the FSM, the counter, the operand and result shift registers, and the output registers.

## Test plan
- WIDTH=8, a=0x35, b=0x12, bin=0, start pulsed -> busy high 8 cycles, done pulse 8 cycles after E0, diff=0x23, bout=0, zero=0, ovf=0.
- a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- With flags enabled: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x35, b=0x35, bin=0 -> diff=0x00, zero=1, bout=0.
- start re-pulsed with new operands mid-RUN -> ignored; result matches the first operands; exactly one done.
- start held through DONE with a=0x10, b=0x01 -> second op accepted at the DONE-exit edge; second done 9 cycles after the first, diff=0x0F.
- rst_n asserted at cycle 4 of RUN -> all outputs 0 immediately; no done; a fresh start after release gives the correct result.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/busy/done handshake plus operand/result bus for serial_sub_ctrl.
// Flag signals exist only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub_ctrl_fs_cell.sv
// One-bit combinational full subtractor: d = x - y - c, nb = borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic nb
);
    assign d  = x ^ y ^ c;
    assign nb = (~x & y) | (c & (~x | y));
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one fs_cell processes operands LSB-first.
// Define SERIAL_SUB_FLAGS_EN to add registered zero/ovf result flags.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_sub_ctrl: WIDTH out of legal range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d, bout_q, bout_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             d, nb, accept, last;
    logic [WIDTH-1:0] res_nx;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
`endif

    fs_cell u_fs (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .c  (borrow_q),
        .d  (d),
        .nb (nb)
    );

    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    assign res_nx = {d, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            state_d  = RUN;
            sa_d     = bus.a;
            sb_d     = bus.b;
            borrow_d = bus.bin;
            cnt_d    = '0;
            res_d    = '0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_d  = bus.a[WIDTH-1];
            b_msb_d  = bus.b[WIDTH-1];
`endif
        end else begin
            case (state_q)
                RUN: begin
                    sa_d     = sa_q >> 1;
                    sb_d     = sb_q >> 1;
                    res_d    = res_nx;
                    borrow_d = nb;
                    // Counter holds on the last bit so it never wraps at power-of-two widths.
                    if (last) begin
                        state_d = DONE;
                        diff_d  = res_nx;
                        bout_d  = nb;
`ifdef SERIAL_SUB_FLAGS_EN
                        zero_d  = (res_nx == '0);
                        ovf_d   = (a_msb_q != b_msb_q) && (d != a_msb_q);
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`endif

endmodule
